code_lock_ctrl: RTL and testbench
=================================

CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

Interface
REQ-001 Parameter DEFAULT_CODE, 16'h1234: four BCD digits loaded as the stored code at reset.
REQ-002 Parameter MAX_FAIL, 3: wrong-code attempts that trigger lockout (range 1..7).
REQ-003 Parameter LOCK_CYCLES, 24'd5_000_000: lockout duration in clk cycles.
REQ-004 Parameter OPEN_CYCLES, 24'd10_000_000: auto-relock timeout in OPEN, in clk cycles.
REQ-005 clk  in  1  single clock for all state; everything updates on posedge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 key_1..key_9  in  1 each  one-cycle digit pulses from the keypad scanner.
REQ-008 key_0  in  1  one-cycle pulse for digit 0 (the scanner's out11 key).
REQ-009 key_clr, key_ok, key_start  in  1 each  one-cycle pulses for the scanner's reset, ok and start keys.
REQ-010 unlock  out  1  high while in OPEN.
REQ-011 alarm  out  1  high while in LOCKOUT.
REQ-012 err  out  1  one-cycle pulse on a rejected code or rejected set.
REQ-013 entry  out  16  four BCD digits of the current buffer, newest digit in [3:0].
REQ-014 digit_cnt  out  3  number of digits entered, 0..4.
REQ-015 fail_cnt  out  3  consecutive wrong attempts.
REQ-016 state  out  3  encoded FSM state, for the display.

Function
REQ-017 Key priority per cycle: key_clr > key_ok > key_start > digits. Among digits, the lowest value wins. Only the winning key is acted on.
REQ-018 FSM states: IDLE, ENTRY, OPEN, SET, LOCKOUT. All transitions are registered, so outputs reflect a key one cycle after its pulse.
REQ-019 Digit entry in ENTRY or SET with digit_cnt<4: entry <= {entry[11:0], d} and digit_cnt increments. A digit with digit_cnt==4 is ignored.
REQ-020 IDLE transitions:
- key_start -> ENTRY, with entry and digit_cnt cleared.
- All other keys are ignored.
REQ-021 ENTRY key_clr: clear entry and digit_cnt; remain in ENTRY.
REQ-022 ENTRY key_ok with digit_cnt==4 and entry==stored code: go to OPEN, clear fail_cnt, load timer with OPEN_CYCLES.
REQ-023 ENTRY key_ok otherwise: pulse err, increment fail_cnt, clear entry and digit_cnt.
- If the new fail_cnt equals MAX_FAIL: go to LOCKOUT and load timer with LOCK_CYCLES.
- Otherwise remain in ENTRY.
REQ-024 ENTRY key_start: clear the buffer; remain in ENTRY.
REQ-025 OPEN transitions:
- key_clr -> IDLE.
- key_start -> SET, with buffer cleared.
- Timer reaching 0 -> IDLE.
- Digits and key_ok are ignored.
REQ-026 SET transitions:
- key_ok with digit_cnt==4: stored code <= entry, go to OPEN, reload OPEN_CYCLES.
- key_ok with digit_cnt<4: pulse err and remain in SET.
- key_clr -> OPEN with the stored code unchanged; timer reloads.
REQ-027 LOCKOUT: all keys are ignored. The timer decrements each cycle; on the cycle it reads 1, go to IDLE and clear fail_cnt.
REQ-028 The timer is 24 bits, decrements only in OPEN and LOCKOUT, and never wraps below 0.
REQ-029 fail_cnt saturates at MAX_FAIL.

Reset
REQ-030 While rst is high, and asynchronously on its assertion, the block holds:
- state=IDLE, entry=0, digit_cnt=0, fail_cnt=0, err=0, unlock=0, alarm=0, timer=0.
- stored code = DEFAULT_CODE.
REQ-031 Reset mid-operation (any state) discards the entry, a code being set, and the lockout; there is no retained memory.

Structure
REQ-032 Shared package lock_pkg holds:
- the state enumeration;
- the DEFAULT_CODE, MAX_FAIL, LOCK_CYCLES and OPEN_CYCLES defaults;
- the digit-width constant (4).
REQ-033 One sub-module, lock_timer: a loadable 24-bit saturating down-counter with load, enable and zero flag, shared by OPEN and LOCKOUT.

Verification
REQ-034 Benches use LOCK_CYCLES=20 and OPEN_CYCLES=30.
REQ-035 start, 1,2,3,4, ok -> unlock=1 one cycle after ok; fail_cnt=0; entry=16'h1234.
REQ-036 start, 1,2,3,5, ok, three times:
- err pulses each time; fail_cnt goes 1, 2, 3.
- alarm=1 after the third ok.
- Keys are ignored during lockout.
- alarm=0 and state=IDLE 20 cycles after entry to LOCKOUT.
REQ-037 In OPEN: start, 9,0,0,7, ok -> stored code is 9007, then clr -> IDLE.
- start, 9,0,0,7, ok -> unlock=1.
- start, 1,2,3,4, ok -> err=1 with no unlock.
REQ-038 start, 1,2,3,4,5,6, ok -> entry=16'h1234, digit_cnt=4, unlock=1. Extra digits are ignored.
REQ-039 Simultaneous key_ok and key_3 in ENTRY with digit_cnt=3 -> ok is evaluated, err=1, and digit 3 is dropped.
REQ-040 Reset corner cases:
- Pulse rst in SET after 2 digits -> IDLE with stored code 16'h1234.
- Open with no keys -> IDLE after 30 cycles.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad code lock: FSM states, default parameters
// and the digit-priority helper.
package lock_pkg;

  localparam int DIGIT_W = 4;
  localparam int ENTRY_W = 4 * DIGIT_W;
  localparam int TIMER_W = 24;

  localparam logic [ENTRY_W-1:0] DEF_CODE        = 16'h1234;
  localparam int                 DEF_MAX_FAIL    = 3;
  localparam logic [TIMER_W-1:0] DEF_LOCK_CYCLES = 24'd5_000_000;
  localparam logic [TIMER_W-1:0] DEF_OPEN_CYCLES = 24'd10_000_000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_SET     = 3'd3,
    ST_LOCKOUT = 3'd4
  } lock_state_e;

  // Lowest pressed digit wins when the scanner reports several at once.
  function automatic logic [DIGIT_W-1:0] lowest_digit(input logic [9:0] keys);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = 9; i >= 0; i--) begin
      if (keys[i]) d = DIGIT_W'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable saturating down-counter used for both the open timeout and the lockout.
module lock_timer
  import lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_en,
  output logic [TIMER_W-1:0] o_count,
  output logic               o_zero
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code lock: four-digit entry, open/relock, code change and lockout
// after repeated wrong attempts.
module code_lock_ctrl
  import lock_pkg::*;
#(
  parameter logic [ENTRY_W-1:0] DEFAULT_CODE = DEF_CODE,
  parameter int                 MAX_FAIL     = DEF_MAX_FAIL,
  parameter logic [TIMER_W-1:0] LOCK_CYCLES  = DEF_LOCK_CYCLES,
  parameter logic [TIMER_W-1:0] OPEN_CYCLES  = DEF_OPEN_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_0,
  input  logic               key_1,
  input  logic               key_2,
  input  logic               key_3,
  input  logic               key_4,
  input  logic               key_5,
  input  logic               key_6,
  input  logic               key_7,
  input  logic               key_8,
  input  logic               key_9,
  input  logic               key_clr,
  input  logic               key_ok,
  input  logic               key_start,
  output logic               unlock,
  output logic               alarm,
  output logic               err,
  output logic [ENTRY_W-1:0] entry,
  output logic [2:0]         digit_cnt,
  output logic [2:0]         fail_cnt,
  output logic [2:0]         state
);

  localparam logic [2:0] MAX_F = 3'(MAX_FAIL);

  lock_state_e        r_state, w_state_nx;
  logic [ENTRY_W-1:0] r_entry, w_entry_nx;
  logic [ENTRY_W-1:0] r_code, w_code_nx;
  logic [2:0]         r_digit_cnt, w_cnt_nx;
  logic [2:0]         r_fail_cnt, w_fail_nx, w_fail_inc;
  logic               r_err, w_err_nx;

  logic [9:0]         w_digits;
  logic [DIGIT_W-1:0] w_digit;
  logic               w_do_digit;
  logic               w_tmr_load, w_tmr_en, w_tmr_zero, w_expire;
  logic [TIMER_W-1:0] w_tmr_val, w_tmr_count;

  assign w_digits   = {key_9, key_8, key_7, key_6, key_5, key_4, key_3, key_2, key_1, key_0};
  assign w_digit    = lowest_digit(w_digits);
  assign w_do_digit = (|w_digits) && !key_clr && !key_ok && !key_start;
  assign w_fail_inc = (r_fail_cnt >= MAX_F) ? MAX_F : r_fail_cnt + 3'd1;

  // Leave on the cycle the timer reads 1 so the dwell is exactly the loaded count.
  assign w_expire = w_tmr_zero || (w_tmr_count == TIMER_W'(1));
  assign w_tmr_en = (r_state == ST_OPEN) || (r_state == ST_LOCKOUT);

  lock_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_count    (w_tmr_count),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_nx = r_state;
    w_entry_nx = r_entry;
    w_cnt_nx   = r_digit_cnt;
    w_fail_nx  = r_fail_cnt;
    w_code_nx  = r_code;
    w_err_nx   = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = OPEN_CYCLES;
    case (r_state)
      ST_IDLE: begin
        if (key_start) begin
          w_state_nx = ST_ENTRY;
          w_entry_nx = '0;
          w_cnt_nx   = '0;
        end
      end
      ST_ENTRY: begin
        if (key_clr || key_start) begin
          w_entry_nx = '0;
          w_cnt_nx   = '0;
        end else if (key_ok) begin
          if ((r_digit_cnt == 3'd4) && (r_entry == r_code)) begin
            w_state_nx = ST_OPEN;
            w_fail_nx  = '0;
            w_tmr_load = 1'b1;
          end else begin
            w_err_nx   = 1'b1;
            w_fail_nx  = w_fail_inc;
            w_entry_nx = '0;
            w_cnt_nx   = '0;
            if (w_fail_inc == MAX_F) begin
              w_state_nx = ST_LOCKOUT;
              w_tmr_load = 1'b1;
              w_tmr_val  = LOCK_CYCLES;
            end
          end
        end else if (w_do_digit && (r_digit_cnt < 3'd4)) begin
          w_entry_nx = {r_entry[ENTRY_W-DIGIT_W-1:0], w_digit};
          w_cnt_nx   = r_digit_cnt + 3'd1;
        end
      end
      ST_OPEN: begin
        if (w_expire || key_clr) begin
          w_state_nx = ST_IDLE;
        end else if (key_start) begin
          w_state_nx = ST_SET;
          w_entry_nx = '0;
          w_cnt_nx   = '0;
        end
      end
      ST_SET: begin
        if (key_clr) begin
          w_state_nx = ST_OPEN;
          w_tmr_load = 1'b1;
        end else if (key_ok) begin
          if (r_digit_cnt == 3'd4) begin
            w_code_nx  = r_entry;
            w_state_nx = ST_OPEN;
            w_tmr_load = 1'b1;
          end else begin
            w_err_nx = 1'b1;
          end
        end else if (w_do_digit && (r_digit_cnt < 3'd4)) begin
          w_entry_nx = {r_entry[ENTRY_W-DIGIT_W-1:0], w_digit};
          w_cnt_nx   = r_digit_cnt + 3'd1;
        end
      end
      ST_LOCKOUT: begin
        if (w_expire) begin
          w_state_nx = ST_IDLE;
          w_fail_nx  = '0;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_entry     <= '0;
      r_code      <= DEFAULT_CODE;
      r_digit_cnt <= '0;
      r_fail_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_entry     <= w_entry_nx;
      r_code      <= w_code_nx;
      r_digit_cnt <= w_cnt_nx;
      r_fail_cnt  <= w_fail_nx;
      r_err       <= w_err_nx;
    end
  end

  assign unlock    = (r_state == ST_OPEN);
  assign alarm     = (r_state == ST_LOCKOUT);
  assign err       = r_err;
  assign entry     = r_entry;
  assign digit_cnt = r_digit_cnt;
  assign fail_cnt  = r_fail_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Self-checking bench for code_lock_ctrl: scripted key sequences with
// hand-derived expected output snapshots queued per key press.
module tb_code_lock_ctrl;
  import lock_pkg::*;

  localparam int W = 28;
  localparam logic [12:0] K_NONE  = 13'h0000;
  localparam logic [12:0] K_CLR   = 13'h0400;
  localparam logic [12:0] K_OK    = 13'h0800;
  localparam logic [12:0] K_START = 13'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] keys = '0;
  logic        unlock, alarm, err;
  logic [15:0] entry;
  logic [2:0]  digit_cnt, fail_cnt, state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got, want;
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  code_lock_ctrl #(
    .LOCK_CYCLES (24'd20),
    .OPEN_CYCLES (24'd30)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_0     (keys[0]),
    .key_1     (keys[1]),
    .key_2     (keys[2]),
    .key_3     (keys[3]),
    .key_4     (keys[4]),
    .key_5     (keys[5]),
    .key_6     (keys[6]),
    .key_7     (keys[7]),
    .key_8     (keys[8]),
    .key_9     (keys[9]),
    .key_clr   (keys[10]),
    .key_ok    (keys[11]),
    .key_start (keys[12]),
    .unlock    (unlock),
    .alarm     (alarm),
    .err       (err),
    .entry     (entry),
    .digit_cnt (digit_cnt),
    .fail_cnt  (fail_cnt),
    .state     (state)
  );

  // ---------------- helpers ----------------
  function automatic logic [12:0] kd(input int d);
    logic [12:0] one;
    one = 13'd1;
    return one << d;
  endfunction

  // Expected snapshot: {state, unlock, alarm, err, fail_cnt, digit_cnt, entry}
  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic er,
                                      input logic [2:0] fc, input logic [2:0] dc,
                                      input logic [15:0] en);
    return {st, (st == ST_OPEN), (st == ST_LOCKOUT), er, fc, dc, en};
  endfunction

  function automatic logic [W-1:0] snap();
    return {state, unlock, alarm, err, fail_cnt, digit_cnt, entry};
  endfunction

  // Drive a key mask for exactly one posedge; returns at the following negedge.
  task automatic press(input logic [12:0] m);
    keys = m;
    @(negedge clk);
    keys = K_NONE;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [12:0] ks[$];
    logic [W-1:0] es[$];
    #1 rst = 1'b1;
    #1;
    got = snap(); want = mk(ST_IDLE, 0, 0, 0, 16'h0000); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_async: got %h expected %h", got, want); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ks = '{K_NONE, kd(5), K_OK, K_CLR};
    es = '{mk(ST_IDLE,0,0,0,0), mk(ST_IDLE,0,0,0,0), mk(ST_IDLE,0,0,0,0), mk(ST_IDLE,0,0,0,0)};
    for (int i = 0; i < ks.size(); i++) begin
      exp_q.push_back(es[i]);
      press(ks[i]);
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL reset[%0d]: got %h expected %h", i, got, want); end
    end
  endtask

  task automatic test_open();
    logic [12:0] ks[$];
    logic [W-1:0] es[$];
    ks = '{K_START, kd(1), kd(2), kd(3), kd(4), K_OK, K_CLR};
    es = '{mk(ST_ENTRY,0,0,0,16'h0000), mk(ST_ENTRY,0,0,1,16'h0001), mk(ST_ENTRY,0,0,2,16'h0012),
           mk(ST_ENTRY,0,0,3,16'h0123), mk(ST_ENTRY,0,0,4,16'h1234), mk(ST_OPEN,0,0,4,16'h1234),
           mk(ST_IDLE,0,0,4,16'h1234)};
    for (int i = 0; i < ks.size(); i++) begin
      exp_q.push_back(es[i]);
      press(ks[i]);
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL open[%0d]: got %h expected %h", i, got, want); end
    end
  endtask

  task automatic test_lockout();
    logic [12:0] ks[$];
    logic [W-1:0] es[$];
    for (int r = 0; r < 3; r++) begin
      ks.push_back(K_START); es.push_back(mk(ST_ENTRY,0,3'(r),0,16'h0000));
      ks.push_back(kd(1));   es.push_back(mk(ST_ENTRY,0,3'(r),1,16'h0001));
      ks.push_back(kd(2));   es.push_back(mk(ST_ENTRY,0,3'(r),2,16'h0012));
      ks.push_back(kd(3));   es.push_back(mk(ST_ENTRY,0,3'(r),3,16'h0123));
      ks.push_back(kd(5));   es.push_back(mk(ST_ENTRY,0,3'(r),4,16'h1235));
      ks.push_back(K_OK);
      es.push_back(mk((r == 2) ? ST_LOCKOUT : ST_ENTRY, 1, 3'(r + 1), 0, 16'h0000));
    end
    // Keys during lockout are ignored; 19 more cycles locked, released on the 20th.
    ks.push_back(K_START); ks.push_back(kd(1)); ks.push_back(K_OK); ks.push_back(K_CLR);
    repeat (15) ks.push_back(K_NONE);
    repeat (19) es.push_back(mk(ST_LOCKOUT,0,3,0,16'h0000));
    ks.push_back(K_NONE); es.push_back(mk(ST_IDLE,0,0,0,16'h0000));
    for (int i = 0; i < ks.size(); i++) begin
      exp_q.push_back(es[i]);
      press(ks[i]);
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL lockout[%0d]: got %h expected %h", i, got, want); end
    end
  endtask

  task automatic test_set_code();
    logic [12:0] ks[$];
    logic [W-1:0] es[$];
    ks = '{K_START, kd(1), kd(2), kd(3), kd(4), K_OK,
           K_START, kd(9), K_OK, kd(0), kd(0), kd(7), K_OK, K_CLR,
           K_START, kd(9), kd(0), kd(0), kd(7), K_OK, K_CLR,
           K_START, kd(1), kd(2), kd(3), kd(4), K_OK, K_NONE};
    es = '{mk(ST_ENTRY,0,0,0,16'h0000), mk(ST_ENTRY,0,0,1,16'h0001), mk(ST_ENTRY,0,0,2,16'h0012),
           mk(ST_ENTRY,0,0,3,16'h0123), mk(ST_ENTRY,0,0,4,16'h1234), mk(ST_OPEN,0,0,4,16'h1234),
           mk(ST_SET,0,0,0,16'h0000), mk(ST_SET,0,0,1,16'h0009), mk(ST_SET,1,0,1,16'h0009),
           mk(ST_SET,0,0,2,16'h0090), mk(ST_SET,0,0,3,16'h0900), mk(ST_SET,0,0,4,16'h9007),
           mk(ST_OPEN,0,0,4,16'h9007), mk(ST_IDLE,0,0,4,16'h9007),
           mk(ST_ENTRY,0,0,0,16'h0000), mk(ST_ENTRY,0,0,1,16'h0009), mk(ST_ENTRY,0,0,2,16'h0090),
           mk(ST_ENTRY,0,0,3,16'h0900), mk(ST_ENTRY,0,0,4,16'h9007), mk(ST_OPEN,0,0,4,16'h9007),
           mk(ST_IDLE,0,0,4,16'h9007),
           mk(ST_ENTRY,0,0,0,16'h0000), mk(ST_ENTRY,0,0,1,16'h0001), mk(ST_ENTRY,0,0,2,16'h0012),
           mk(ST_ENTRY,0,0,3,16'h0123), mk(ST_ENTRY,0,0,4,16'h1234), mk(ST_ENTRY,1,1,0,16'h0000),
           mk(ST_ENTRY,0,1,0,16'h0000)};
    for (int i = 0; i < ks.size(); i++) begin
      exp_q.push_back(es[i]);
      press(ks[i]);
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL set_code[%0d]: got %h expected %h", i, got, want); end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] ks[$];
    logic [W-1:0] es[$];
    // From ENTRY (fail_cnt=1): open with 9007, enter SET, type two digits.
    ks = '{K_START, kd(9), kd(0), kd(0), kd(7), K_OK, K_START, kd(1), kd(2)};
    es = '{mk(ST_ENTRY,0,1,0,16'h0000), mk(ST_ENTRY,0,1,1,16'h0009), mk(ST_ENTRY,0,1,2,16'h0090),
           mk(ST_ENTRY,0,1,3,16'h0900), mk(ST_ENTRY,0,1,4,16'h9007), mk(ST_OPEN,0,0,4,16'h9007),
           mk(ST_SET,0,0,0,16'h0000), mk(ST_SET,0,0,1,16'h0001), mk(ST_SET,0,0,2,16'h0012)};
    for (int i = 0; i < ks.size(); i++) begin
      exp_q.push_back(es[i]);
      press(ks[i]);
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL reset_mid[%0d]: got %h expected %h", i, got, want); end
    end
    #2 rst = 1'b1;
    #1;
    got = snap(); want = mk(ST_IDLE, 0, 0, 0, 16'h0000); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_mid_async: got %h expected %h", got, want); end
    @(negedge clk);
    rst = 1'b0;
    // The default code must be back in force.
    ks = '{K_START, kd(1), kd(2), kd(3), kd(4), K_OK};
    es = '{mk(ST_ENTRY,0,0,0,16'h0000), mk(ST_ENTRY,0,0,1,16'h0001), mk(ST_ENTRY,0,0,2,16'h0012),
           mk(ST_ENTRY,0,0,3,16'h0123), mk(ST_ENTRY,0,0,4,16'h1234), mk(ST_OPEN,0,0,4,16'h1234)};
    for (int i = 0; i < ks.size(); i++) begin
      exp_q.push_back(es[i]);
      press(ks[i]);
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL reset_code[%0d]: got %h expected %h", i, got, want); end
    end
  endtask

  task automatic test_open_timeout();
    // Entered OPEN on the previous press; stays 29 more cycles, IDLE on the 30th.
    for (int i = 0; i < 30; i++) begin
      exp_q.push_back((i < 29) ? mk(ST_OPEN,0,0,4,16'h1234) : mk(ST_IDLE,0,0,4,16'h1234));
      press(K_NONE);
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL open_timeout[%0d]: got %h expected %h", i, got, want); end
    end
  endtask

  task automatic test_extra_digits();
    logic [12:0] ks[$];
    logic [W-1:0] es[$];
    ks = '{K_START, kd(1), kd(2), kd(3), kd(4), kd(5), kd(6), K_OK, K_CLR};
    es = '{mk(ST_ENTRY,0,0,0,16'h0000), mk(ST_ENTRY,0,0,1,16'h0001), mk(ST_ENTRY,0,0,2,16'h0012),
           mk(ST_ENTRY,0,0,3,16'h0123), mk(ST_ENTRY,0,0,4,16'h1234), mk(ST_ENTRY,0,0,4,16'h1234),
           mk(ST_ENTRY,0,0,4,16'h1234), mk(ST_OPEN,0,0,4,16'h1234), mk(ST_IDLE,0,0,4,16'h1234)};
    for (int i = 0; i < ks.size(); i++) begin
      exp_q.push_back(es[i]);
      press(ks[i]);
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL extra_digits[%0d]: got %h expected %h", i, got, want); end
    end
  endtask

  task automatic test_priority();
    logic [12:0] ks[$];
    logic [W-1:0] es[$];
    int d_hi;
    d_hi = $urandom_range(9, 3);
    ks = '{K_START, kd(1), kd(2), kd(3), K_OK | kd(3), kd(d_hi) | kd(2), K_START | kd(5),
           K_CLR | K_OK | kd(4), kd(1), kd(2), kd(3), kd(4), K_OK, K_CLR};
    es = '{mk(ST_ENTRY,0,0,0,16'h0000), mk(ST_ENTRY,0,0,1,16'h0001), mk(ST_ENTRY,0,0,2,16'h0012),
           mk(ST_ENTRY,0,0,3,16'h0123), mk(ST_ENTRY,1,1,0,16'h0000), mk(ST_ENTRY,0,1,1,16'h0002),
           mk(ST_ENTRY,0,1,0,16'h0000), mk(ST_ENTRY,0,1,0,16'h0000),
           mk(ST_ENTRY,0,1,1,16'h0001), mk(ST_ENTRY,0,1,2,16'h0012), mk(ST_ENTRY,0,1,3,16'h0123),
           mk(ST_ENTRY,0,1,4,16'h1234), mk(ST_OPEN,0,0,4,16'h1234), mk(ST_IDLE,0,0,4,16'h1234)};
    for (int i = 0; i < ks.size(); i++) begin
      exp_q.push_back(es[i]);
      press(ks[i]);
      got = snap(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL priority[%0d]: got %h expected %h", i, got, want); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_open();
    test_lockout();
    test_set_code();
    test_reset_mid();
    test_open_timeout();
    test_extra_digits();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
